counter_access_arbiter: RTL

- Round-robin controller that shares the 16-bit up/down counter datapath (C register, z/m flags) among NREQ requesters.
- Each requester issues up/down increments with a request/ack handshake.
- The block sequences the datapath's c_clr, c_ld and op controls, and refuses operations that would underflow or overflow.
- Sits between the requester logic (debounced buttons or other masters) and the counter datapath, in place of the single-user FSM.

---
 rtl/counter_access_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/counter_access_arbiter.sv
// Round-robin arbiter sharing the 16-bit up/down counter datapath among NREQ
// requesters; refuses operations that would saturate or underflow using z/m.
module counter_access_arbiter #(
   parameter int NREQ = 4,
   parameter int IDXW = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req_up,
   input  logic [NREQ-1:0] req_dn,
   input  logic            clr_req,
   input  logic            z,
   input  logic            m,
   output logic            op,
   output logic            c_ld,
   output logic            c_clr,
   output logic [NREQ-1:0] gnt,
   output logic [IDXW-1:0] gnt_idx,
   output logic            ack,
   output logic            nack,
   output logic [2:0]      state
);

   // state    | meaning
   // INICIO   | after reset, clear the counter
   // ESPERA   | one idle cycle before arbitration starts
   // VERIFICA | arbitrate; check clear request, conflicts, saturation, underflow
   // EXECUTA  | pulse c_ld with op selected for the winner
   // RESPONDE | ack or nack the winner, advance rr pointer, disarm winner
   // LIMPA    | clear the counter on clr_req
   typedef enum logic [2:0] {
      INICIO   = 3'b000,
      ESPERA   = 3'b001,
      VERIFICA = 3'b010,
      EXECUTA  = 3'b011,
      RESPONDE = 3'b100,
      LIMPA    = 3'b101
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [IDXW-1:0] r_rr;
   logic [IDXW-1:0] r_gnt_idx;
   logic [IDXW-1:0] w_sel;
   logic [NREQ-1:0] r_armed;
   logic [NREQ-1:0] w_armed_next;
   logic [NREQ-1:0] w_elig;
   logic            r_op;
   logic            r_refused;
   logic            w_found;
   logic            w_sel_up;
   logic            w_sel_dn;
   logic            w_refuse;
   logic            w_take;

   function automatic logic [IDXW-1:0] idx_add(input logic [IDXW-1:0] a, input int b);
      int s;
      s = int'(a) + b;
      if (s >= NREQ) s = s - NREQ;
      return s[IDXW-1:0];
   endfunction

   // First eligible requester at or after the rr pointer, wrapping.
   always_comb begin
      w_elig  = r_armed & (req_up | req_dn);
      w_found = 1'b0;
      w_sel   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_found && w_elig[idx_add(r_rr, k)]) begin
            w_found = 1'b1;
            w_sel   = idx_add(r_rr, k);
         end
      end
      w_sel_up = req_up[w_sel];
      w_sel_dn = req_dn[w_sel];
      w_refuse = (w_sel_up & w_sel_dn) | (w_sel_up & m) | (w_sel_dn & z);
      w_take   = (r_state == VERIFICA) && !clr_req && w_found;
   end

   always_comb begin
      w_armed_next = r_armed | ~(req_up | req_dn);
      if (r_state == RESPONDE) w_armed_next[r_gnt_idx] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= INICIO;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      c_ld   = 1'b0;
      c_clr  = 1'b0;
      ack    = 1'b0;
      nack   = 1'b0;
      gnt    = '0;
      case (r_state)
         INICIO: begin
            c_clr  = 1'b1;
            w_next = ESPERA;
         end
         ESPERA:   w_next = VERIFICA;
         VERIFICA: begin
            if (clr_req)      w_next = LIMPA;
            else if (w_found) w_next = w_refuse ? RESPONDE : EXECUTA;
         end
         EXECUTA: begin
            c_ld   = 1'b1;
            w_next = RESPONDE;
         end
         RESPONDE: begin
            ack    = !r_refused;
            nack   = r_refused;
            gnt    = {{(NREQ-1){1'b0}}, 1'b1} << r_gnt_idx;
            w_next = VERIFICA;
         end
         LIMPA: begin
            c_clr  = 1'b1;
            w_next = VERIFICA;
         end
         default:  w_next = INICIO;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rr      <= '0;
         r_gnt_idx <= '0;
         r_op      <= 1'b0;
         r_refused <= 1'b0;
         r_armed   <= '1;
      end else begin
         r_armed <= w_armed_next;
         if (w_take) begin
            r_gnt_idx <= w_sel;
            r_refused <= w_refuse;
            if (!w_refuse) r_op <= w_sel_up;
         end
         if (r_state == RESPONDE) r_rr <= idx_add(r_gnt_idx, 1);
      end
   end

   assign op      = r_op;
   assign gnt_idx = r_gnt_idx;
   assign state   = r_state;

endmodule
